// File: rtl/wcu_pkg.sv
// Shared state encoding and salvo-length helper for the salvo weapons control unit.
package wcu_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_FIRE     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_EMPTY    = 3'd4
  } wcu_state_e;

  // A request of zero still fires one missile; anything above max is clamped.
  function automatic logic [3:0] clamp_salvo(input logic [3:0] req, input logic [3:0] max);
    if (req == 4'd0) return 4'd1;
    if (req > max)   return max;
    return req;
  endfunction
endpackage

// File: rtl/wcu_cooldown_timer.sv
// Loadable down-counter; done_o is high whenever the count has reached zero.
module wcu_cooldown_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);
endmodule

// File: rtl/salvo_weapons_control_unit.sv
// Salvo fire controller: lock, fire on command edge, round-robin tubes, cooldown, magazine tracking.
// Define WCU_RELOAD_EN to add a reload input that refills the magazine from IDLE or EMPTY.
module salvo_weapons_control_unit
  import wcu_pkg::*;
#(
  parameter int NUM_TUBES       = 2,
  parameter int MAG_DEPTH       = 8,
  parameter int CNT_W           = 4,
  parameter int SALVO_MAX       = 4,
  parameter int COOLDOWN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef WCU_RELOAD_EN
  input  logic                 reload,
`endif
  input  logic                 target_locked,
  input  logic                 fire_command,
  input  logic [3:0]           salvo_size,
  output logic [NUM_TUBES-1:0] launch_missile,
  output logic [CNT_W-1:0]     remaining_missiles,
  output logic [STATE_W-1:0]   wcu_state,
  output logic                 salvo_done
);
  localparam int PTR_W = (NUM_TUBES > 1) ? $clog2(NUM_TUBES) : 1;
  localparam int CD_W  = $clog2(COOLDOWN_CYCLES + 1);
  localparam int CMP_W = CNT_W + 4;

  wcu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [NUM_TUBES-1:0] launch_q, launch_d;
  logic                 done_q, done_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_nxt;
  logic [3:0]           shots_q, shots_d, len_q, len_d;
  logic [3:0]           req_len, eff_len;
  logic                 fire_q, fire_rise, fire_now;
  logic                 cd_load, cd_done, reload_req;

`ifdef WCU_RELOAD_EN
  assign reload_req = reload;
`else
  assign reload_req = 1'b0;
`endif

  assign fire_rise = fire_command & ~fire_q;
  assign req_len   = clamp_salvo(salvo_size, 4'(SALVO_MAX));
  assign eff_len   = (CMP_W'(rem_q) < CMP_W'(req_len)) ? 4'(rem_q) : req_len;
  assign ptr_nxt   = (ptr_q == PTR_W'(NUM_TUBES - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    launch_d = '0;
    done_d   = 1'b0;
    ptr_d    = ptr_q;
    shots_d  = shots_q;
    len_d    = len_q;
    cd_load  = 1'b0;
    fire_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reload_req)         rem_d   = CNT_W'(MAG_DEPTH);
        else if (target_locked) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!target_locked) state_d = ST_IDLE;
        else if (fire_rise && rem_q != '0) begin
          // First launch happens on FIRE entry so every FIRE cycle carries one strobe.
          state_d  = ST_FIRE;
          len_d    = eff_len;
          shots_d  = 4'd0;
          fire_now = 1'b1;
        end
      end
      ST_FIRE: begin
        if (!target_locked || shots_q == len_q) begin
          state_d = ST_COOLDOWN;
          done_d  = 1'b1;
          cd_load = 1'b1;
        end else fire_now = 1'b1;
      end
      ST_COOLDOWN: begin
        if (cd_done) begin
          if (rem_q == '0)        state_d = ST_EMPTY;
          else if (target_locked) state_d = ST_LOCKED;
          else                    state_d = ST_IDLE;
        end
      end
      ST_EMPTY: begin
        if (reload_req) begin
          state_d = ST_IDLE;
          rem_d   = CNT_W'(MAG_DEPTH);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fire_now && rem_q != '0) begin
      launch_d = NUM_TUBES'(1) << ptr_q;
      rem_d    = rem_q - CNT_W'(1);
      ptr_d    = ptr_nxt;
      shots_d  = shots_d + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= CNT_W'(MAG_DEPTH);
      launch_q <= '0;
      done_q   <= 1'b0;
      ptr_q    <= '0;
      shots_q  <= 4'd0;
      len_q    <= 4'd0;
      fire_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      launch_q <= launch_d;
      done_q   <= done_d;
      ptr_q    <= ptr_d;
      shots_q  <= shots_d;
      len_q    <= len_d;
      fire_q   <= fire_command;
    end
  end

  // Loaded with N-1 so the count sits at zero during the last of N cooldown cycles.
  wcu_cooldown_timer #(.W(CD_W)) u_cooldown (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cd_load),
    .load_val_i (CD_W'(COOLDOWN_CYCLES - 1)),
    .done_o     (cd_done)
  );

  assign launch_missile     = launch_q;
  assign remaining_missiles = rem_q;
  assign wcu_state          = state_q;
  assign salvo_done         = done_q;
endmodule
